seq_mult_radix: RTL and testbench
=================================

Name: seq_mult_radix

Overview:
Parametrised iterative integer multiplier. It is the successor to the one-bit-per-cycle shift-add unit.
- Retires K multiplier bits per cycle.
- Supports a per-operation signed or unsigned mode.
- Uses valid/ready handshakes on both input and output.
- Serves as the leaf multiplier under Karatsuba-style wrappers in the datapath.

Parameters:
N, 64, operand width in bits (N >= 4).
K, 2, multiplier bits consumed per cycle. Legal values are 1, 2 and 4. N must be a multiple of K (elaboration error otherwise).
R, 2*N, result width (localparam).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  operands a, b, sgn are valid
in_ready  out  1  block can accept an operation
a  in  N  multiplicand
b  in  N  multiplier
sgn  in  1  1 = both operands are two's complement; 0 = both unsigned
out_valid  out  1  res holds a finished product
out_ready  in  1  consumer accepts res
res  out  R  product
busy  out  1  state != IDLE

Behaviour:
- Reset values: in_ready=1, out_valid=0, res=0, busy=0, state=IDLE, all internal registers 0. Reset takes effect immediately, including mid-operation; the in-flight operation is discarded with no output.
- States:
  - IDLE: in_ready=1.
  - RUN: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- Accept occurs on an edge where in_valid && in_ready.
  - Latch neg = sgn & (a[N-1] ^ b[N-1]).
  - Latch magnitudes |a|, |b| (unsigned N-bit). |-2^(N-1)| = 2^(N-1) fits N bits unsigned.
  - Clear the accumulator and go to RUN.
- RUN step (one per edge):
  - accum += (mag_a * b_mag[K-1:0]) << (K*step).
  - mag_b >>= K; step++.
  - K-bit partial products are formed combinationally. Accumulator width is R; no overflow is possible.
- Finish:
  - Finish after the step where step reaches N/K.
  - On the finishing edge: res <= neg ? -accum_next : accum_next (R-bit two's complement), then go to DONE.
  - Fixed latency: out_valid rises N/K cycles after the accept edge.
- DONE:
  - res and out_valid are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid<=0 and go to IDLE.
  - A new operation can be accepted on the following edge at the earliest. No overlap; throughput is one op per N/K+2 cycles.
- res keeps its last value in IDLE and RUN. It changes only on the finishing edge.
- Unsigned mode: a, b are used as-is and neg=0.
- in_valid while not in_ready: ignored; the operands are not sampled.
- Operand inputs need only be stable on the accept edge.

Optional Feature:
Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined:
  - RUN finishes on the first edge where the shifted remaining multiplier magnitude becomes 0, with the same res/negate update.
  - If |b|==0 at accept, the block goes straight to DONE with res=0; out_valid rises 1 cycle after accept.
  - Latency = max(1, ceil(msb_index(|b|)+1)/K) cycles.
- Not defined: fixed N/K-cycle latency for all operands.

Test Plan:
- N=8,K=2,sgn=0: a=3, b=5, out_ready=1 -> res=16'h000F.
  - out_valid rises exactly 4 cycles after accept.
  - With SEQ_MULT_EARLY_TERM_EN, it rises 2 cycles after accept.
- N=8,K=2,sgn=1: a=8'hFD (-3), b=8'h05 -> res=16'hFFF1 (-15).
- N=8,K=2,sgn=1: a=b=8'h80 (-128) -> res=16'h4000. Also a=8'h80, b=8'h01 -> res=16'hFF80.
- Backpressure:
  - a=255, b=255, sgn=0, out_ready=0 for 5 cycles after out_valid.
  - During that time, res=16'hFE01 is held stable, in_ready=0, and a second in_valid is ignored.
  - After out_ready=1, the block returns to IDLE; the next op (a=2, b=7) yields 16'h000E.
- b=0, a=8'hAB:
  - Without the macro: res=0 after 4 cycles.
  - With SEQ_MULT_EARLY_TERM_EN: res=0 with out_valid 1 cycle after accept.
- Reset mid-operation: assert rst asynchronously 2 cycles after accepting 3*5.
  - Required: immediately in_ready=1, out_valid=0, res=0, busy=0.
  - No stale out_valid after release.
  - The next op 6*7 yields 16'h002A.

Source files
------------

// File: rtl/seq_mult_radix.sv
// Iterative radix-2^K multiplier with valid/ready handshakes and per-op signed mode.
// Define SEQ_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier magnitude is zero.
module seq_mult_radix #(
  parameter int N = 64,
  parameter int K = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           sgn,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] res,
  output logic           busy
);
  localparam int R     = 2 * N;
  localparam int STEPS = N / K;
  localparam int SW    = $clog2(STEPS + 1);

  generate
    if (N < 4 || !(K == 1 || K == 2 || K == 4) || (N % K) != 0) begin : g_bad_param
      $error("seq_mult_radix: illegal N/K combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   mag_a_q, mag_a_d;
  logic [N-1:0]   mag_b_q, mag_b_d;
  logic [R-1:0]   accum_q, accum_d;
  logic [SW-1:0]  step_q, step_d;
  logic           neg_q, neg_d;
  logic [R-1:0]   res_q, res_d;

  logic [N+K-1:0] pp;
  logic [R-1:0]   pp_shifted;
  logic [R-1:0]   accum_next;
  logic [N-1:0]   mag_b_shift;
  logic           finish;

  // One K-bit digit of the multiplier per cycle, weighted by its position.
  always_comb begin
    pp          = (N+K)'(mag_a_q) * (N+K)'(mag_b_q[K-1:0]);
    pp_shifted  = R'(pp) << (K * step_q);
    accum_next  = accum_q + pp_shifted;
    mag_b_shift = mag_b_q >> K;
  end

  always_comb begin
    state_d = state_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    accum_d = accum_q;
    step_d  = step_q;
    neg_d   = neg_q;
    res_d   = res_q;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          neg_d   = sgn & (a[N-1] ^ b[N-1]);
          mag_a_d = (sgn && a[N-1]) ? -a : a;
          mag_b_d = (sgn && b[N-1]) ? -b : b;
          accum_d = '0;
          step_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        accum_d = accum_next;
        mag_b_d = mag_b_shift;
        step_d  = step_q + SW'(1);
`ifdef SEQ_MULT_EARLY_TERM_EN
        finish  = (mag_b_shift == '0);
`else
        finish  = (step_d == SW'(STEPS));
`endif
        if (finish) begin
          res_d   = neg_q ? -accum_next : accum_next;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      accum_q <= '0;
      step_q  <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      accum_q <= accum_d;
      step_q  <= step_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res       = res_q;

endmodule

// File: tb/tb_seq_mult_radix.sv
// Scoreboard bench for seq_mult_radix (N=8, K=2): driver pushes expectations, monitor checks outputs.
module tb_seq_mult_radix;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        sgn;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] res;
  logic        busy;

  seq_mult_radix #(.N(8), .K(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sgn(sgn), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per out_valid rise, checks res held while stalled.
  initial begin : monitor
    logic prev;
    exp_t cur;
    prev = 1'b0;
    cur  = '{16'h0, 0, 0};
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (out_valid) begin
        if (!prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: got res %h expected no output", res);
            cur = '{res, 0, 0};
          end else begin
            cur = exp_q.pop_front();
            chk("res", 32'(res), 32'(cur.res));
            chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
            $display("op done: res=%h latency=%0d", res, cyc - cur.acc);
          end
        end else begin
          chk("res_hold", 32'(res), 32'(cur.res));
        end
      end
      prev = out_valid;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic do_op(input logic [7:0] ai, input logic [7:0] bi, input logic si,
                       input logic [15:0] er, input int lat_fixed, input int lat_early,
                       input bit push);
    int lat;
`ifdef SEQ_MULT_EARLY_TERM_EN
    lat = lat_early;
`else
    lat = lat_fixed;
`endif
    wait_ready();
    a = ai; b = bi; sgn = si; in_valid = 1'b1;
    if (push) exp_q.push_back('{er, lat, cyc + 1});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin : stim
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sgn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_res", 32'(res), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(8'd3,   8'd5,   1'b0, 16'h000F, 4, 2, 1);
    do_op(8'hFD,  8'h05,  1'b1, 16'hFFF1, 4, 2, 1);
    do_op(8'h80,  8'h80,  1'b1, 16'h4000, 4, 4, 1);
    do_op(8'h80,  8'h01,  1'b1, 16'hFF80, 4, 1, 1);
    do_op(8'h7F,  8'h81,  1'b1, 16'hC0FF, 4, 4, 1);
    do_op(8'hFD,  8'h05,  1'b0, 16'h04F1, 4, 2, 1);

    // Backpressure: hold result for 5 cycles while a stray request is offered.
    wait_ready();
    out_ready = 1'b0;
    do_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 4, 4, 1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    repeat (5) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      a = 8'd1; b = 8'd1; sgn = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    do_op(8'd2,   8'd7,   1'b0, 16'h000E, 4, 2, 1);
    do_op(8'hAB,  8'h00,  1'b0, 16'h0000, 4, 1, 1);

    // Asynchronous reset mid-operation; the op must vanish.
    do_op(8'd3, 8'd5, 1'b0, 16'h000F, 4, 2, 0);
    @(posedge clk);
    #4 rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_res", 32'(res), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    do_op(8'd6, 8'd7, 1'b0, 16'h002A, 4, 2, 1);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
